ex_shll_seq: RTL and testbench

EX_SHLL_SEQ -- requirements
Module: ex_shll_seq

---
 rtl/ex_shll_seq.sv | 111 +++++++++++
 tb/tb_ex_shll_seq.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/ex_shll_seq.sv
// Multi-cycle 64-bit shifter/rotator: one power-of-two step per cycle, taken from the highest set count bit.
// Result is held in DONE until acknowledged; flush returns to IDLE without touching the result register.
module ex_shll_seq (
  input  logic        clock,
  input  logic        reset,
  input  logic        regInValid,
  input  logic [1:0]  regInOp,
  input  logic [5:0]  regInShAmt,
  input  logic [63:0] regValRm,
  input  logic        regInAck,
  input  logic        regInFlush,
  output logic [63:0] regOutVal,
  output logic        regOutOk,
  output logic        regOutBusy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [1:0] OP_SHL = 2'd0;
  localparam logic [1:0] OP_SHR = 2'd1;
  localparam logic [1:0] OP_SAR = 2'd2;
  localparam logic [1:0] OP_ROL = 2'd3;

  state_t      state_q, state_d;
  logic [63:0] val_q, val_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [1:0]  op_q, op_d;

  logic [5:0]  step;
  logic [5:0]  cnt_rem;
  logic [63:0] stepped;

  // Largest power of two still pending in the count.
  always_comb begin
    step = 6'd0;
    if (cnt_q[5])      step = 6'd32;
    else if (cnt_q[4]) step = 6'd16;
    else if (cnt_q[3]) step = 6'd8;
    else if (cnt_q[2]) step = 6'd4;
    else if (cnt_q[1]) step = 6'd2;
    else if (cnt_q[0]) step = 6'd1;
  end

  assign cnt_rem = cnt_q & ~step;

  // Arithmetic shifts keep bit 63 fixed, so val_q[63] is still the captured sign.
  always_comb begin
    stepped = val_q;
    case (op_q)
      OP_SHL:  stepped = val_q << step;
      OP_SHR:  stepped = val_q >> step;
      OP_SAR:  stepped = $unsigned($signed(val_q) >>> step);
      OP_ROL:  stepped = (val_q << step) | (val_q >> (7'd64 - {1'b0, step}));
      default: stepped = val_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    if (regInFlush) begin
      state_d = S_IDLE;
      cnt_d   = 6'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (regInValid) begin
            val_d   = regValRm;
            cnt_d   = regInShAmt;
            op_d    = regInOp;
            state_d = (regInShAmt != 6'd0) ? S_SHIFT : S_DONE;
          end
        end
        S_SHIFT: begin
          val_d = stepped;
          cnt_d = cnt_rem;
          if (cnt_rem == 6'd0) state_d = S_DONE;
        end
        S_DONE: begin
          if (regInAck) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      val_q   <= 64'd0;
      cnt_q   <= 6'd0;
      op_q    <= 2'd0;
    end else begin
      state_q <= state_d;
      val_q   <= val_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

  assign regOutVal  = val_q;
  assign regOutOk   = (state_q == S_DONE);
  assign regOutBusy = (state_q != S_IDLE);

endmodule

// File: tb/tb_ex_shll_seq.sv
// Scoreboard bench for ex_shll_seq: expected results/latencies queued at start, compared when regOutOk rises.
module tb_ex_shll_seq;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        regInValid = 1'b0;
  logic [1:0]  regInOp = 2'd0;
  logic [5:0]  regInShAmt = 6'd0;
  logic [63:0] regValRm = 64'd0;
  logic        regInAck = 1'b0;
  logic        regInFlush = 1'b0;
  logic [63:0] regOutVal;
  logic        regOutOk;
  logic        regOutBusy;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_q[$];
  int          lat_q[$];

  ex_shll_seq dut (
    .clock      (clock),
    .reset      (reset),
    .regInValid (regInValid),
    .regInOp    (regInOp),
    .regInShAmt (regInShAmt),
    .regValRm   (regValRm),
    .regInAck   (regInAck),
    .regInFlush (regInFlush),
    .regOutVal  (regOutVal),
    .regOutOk   (regOutOk),
    .regOutBusy (regOutBusy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [1:0] op, input logic [5:0] amt, input logic [63:0] v);
    logic [63:0] r;
    case (op)
      2'd0:    r = v << amt;
      2'd1:    r = v >> amt;
      2'd2:    r = $unsigned($signed(v) >>> amt);
      default: r = (amt == 6'd0) ? v : ((v << amt) | (v >> (7'd64 - {1'b0, amt})));
    endcase
    return r;
  endfunction

  // Start one operation, wait for the result, hold it for 'hold' cycles, then acknowledge.
  task automatic run(input string tag, input logic [1:0] op, input logic [5:0] amt, input logic [63:0] v,
                     input int hold, input bit keep_valid);
    int n;
    logic [63:0] e;
    int l;
    @(negedge clock);
    regInValid = 1'b1;
    regInOp    = op;
    regInShAmt = amt;
    regValRm   = v;
    exp_q.push_back(model(op, amt, v));
    lat_q.push_back((amt == 6'd0) ? 1 : $countones(amt) + 1);
    @(posedge clock);
    n = 0;
    do begin
      @(negedge clock);
      n++;
      if (keep_valid) begin
        regValRm   = ~v;
        regInShAmt = ~amt;
        regInOp    = ~op;
      end else begin
        regInValid = 1'b0;
      end
    end while (!regOutOk && n < 200);
    e = exp_q.pop_front();
    l = lat_q.pop_front();
    if (!regOutOk) begin
      check({tag, " timeout"}, 64'(regOutOk), 64'd1);
      regInValid = 1'b0;
      return;
    end
    check({tag, " value"}, regOutVal, e);
    check({tag, " latency"}, 64'(n), 64'(l));
    check({tag, " busy"}, 64'(regOutBusy), 64'd1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      check({tag, " hold ok"}, 64'(regOutOk), 64'd1);
      check({tag, " hold value"}, regOutVal, e);
    end
    regInAck = 1'b1;
    @(negedge clock);
    regInAck = 1'b0;
    check({tag, " idle busy"}, 64'(regOutBusy), 64'd0);
    check({tag, " idle ok"}, 64'(regOutOk), 64'd0);
    check({tag, " idle value"}, regOutVal, e);
    regInValid = 1'b0;
  endtask

  initial begin
    int n;
    #1;
    check("reset ok", 64'(regOutOk), 64'd0);
    check("reset busy", 64'(regOutBusy), 64'd0);
    check("reset value", regOutVal, 64'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;

    run("shl63", 2'd0, 6'd63, 64'h0000_0000_0000_0001, 0, 1'b0);
    check("shl63 const", regOutVal, 64'h8000_0000_0000_0000);
    run("sar4", 2'd2, 6'd4, 64'h8000_0000_0000_0000, 0, 1'b0);
    check("sar4 const", regOutVal, 64'hF800_0000_0000_0000);
    run("shr4", 2'd1, 6'd4, 64'h8000_0000_0000_0000, 0, 1'b0);
    check("shr4 const", regOutVal, 64'h0800_0000_0000_0000);
    run("rol1", 2'd3, 6'd1, 64'h8000_0000_0000_0001, 0, 1'b0);
    check("rol1 const", regOutVal, 64'h0000_0000_0000_0003);
    run("shr0", 2'd1, 6'd0, 64'h1234_5678_9ABC_DEF0, 3, 1'b0);
    check("shr0 const", regOutVal, 64'h1234_5678_9ABC_DEF0);

    // Start held high through SHIFT and into the ack cycle: no recapture, no back-to-back start.
    run("validhi", 2'd3, 6'd45, 64'hDEAD_BEEF_0123_4567, 1, 1'b1);

    // Flush on the second SHIFT cycle: one step (32) has already been applied.
    @(negedge clock);
    regInValid = 1'b1; regInOp = 2'd0; regInShAmt = 6'h3F; regValRm = 64'd1;
    @(negedge clock);
    regInValid = 1'b0;
    @(negedge clock);
    regInFlush = 1'b1;
    @(negedge clock);
    regInFlush = 1'b0;
    check("flush busy", 64'(regOutBusy), 64'd0);
    check("flush ok", 64'(regOutOk), 64'd0);
    check("flush value", regOutVal, 64'h0000_0001_0000_0000);
    @(negedge clock);
    check("flush stays idle", 64'(regOutBusy), 64'd0);
    run("postflush", 2'd2, 6'd7, 64'h8000_0000_0000_0F00, 0, 1'b0);

    // Async reset pulse while in DONE, between clock edges.
    @(negedge clock);
    regInValid = 1'b1; regInOp = 2'd0; regInShAmt = 6'd3; regValRm = 64'h5;
    @(negedge clock);
    regInValid = 1'b0;
    n = 0;
    while (!regOutOk && n < 50) begin
      @(negedge clock);
      n++;
    end
    check("pre-reset done", 64'(regOutOk), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("async rst ok", 64'(regOutOk), 64'd0);
    check("async rst busy", 64'(regOutBusy), 64'd0);
    check("async rst value", regOutVal, 64'd0);
    #1 reset = 1'b0;
    run("postreset", 2'd1, 6'd21, 64'hFFFF_0000_AAAA_5555, 0, 1'b0);

    for (int k = 0; k < 12; k++) begin
      logic [1:0]  rop;
      logic [5:0]  ramt;
      logic [63:0] rv;
      rop  = 2'($urandom_range(0, 3));
      ramt = 6'($urandom_range(0, 63));
      rv   = {32'($urandom), 32'($urandom)};
      run("random", rop, ramt, rv, k % 3, 1'(k % 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
